mul_pipe: RTL and testbench
===========================

// Module: mul_pipe
// PURPOSE
//  Parametrised, registered multiply pipeline for the MUL functional unit.
//  Iterative-chunk unsigned multiplier: each stage adds one partial product of srcB.
//  Carries ROB id/PC/dest/exceptions alongside; raises mul overflow at final stage.
//  Sits between the decode/issue path and the ROB/RF writeback.
//  Supports pipeline stall and full flush.
// PARAMETERS
//  NUM_STAGES   4   pipeline depth = latency in cycles; DATA_WIDTH % NUM_STAGES == 0 (elab error otherwise)
//  DATA_WIDTH   32  operand/result width; must equal `REG_FILE_DATA width
// PORTS
//  clock               in   1                     core clock
//  reset               in   1                     synchronous, active-low reset
//  stall_in            in   1                     downstream stall: freeze all stages
//  flush_in            in   1                     kill every in-flight instruction
//  instr_valid_in      in   1                     new op presented
//  instr_id_in         in   `ROB_ID_RANGE         ROB id
//  program_counter_in  in   `PC_WIDTH             PC of op
//  dest_reg_in         in   `REG_FILE_ADDR_RANGE  destination register
//  src_a_in, src_b_in  in   DATA_WIDTH            operands (unsigned)
//  op_high_in          in   1                     1: return upper DATA_WIDTH bits of product
//  xcpt_fetch_in       in   fetch_xcpt_t          upstream exceptions
//  xcpt_decode_in      in   decode_xcpt_t
//  instr_valid_out     out  1                     result valid
//  instr_id_out / program_counter_out / dest_reg_out   out  as inputs
//  data_result_out     out  DATA_WIDTH            product (low or high half)
//  xcpt_fetch_out / xcpt_decode_out   out  passed through
//  xcpt_mul_out        out  mul_xcpt_t            overflow exception
//  busy_out            out  1                     any stage holds a valid op
// BEHAVIOUR
//  - Reset (reset==0 at posedge): all stage valids 0, accumulators 0, all outputs 0.
//  - Chunk C = DATA_WIDTH/NUM_STAGES. Stage k (0..N-1) registers:
//    acc_k = acc_{k-1} + ((2*DATA_WIDTH)'(a) * b[k*C +: C]) << (k*C); acc_{-1}=0.
//    acc is 2*DATA_WIDTH bits, never wraps. a, b, op_high, metadata ride with op.
//  - Latency: op accepted at edge t (valid_in, !stall, !flush) is on outputs after
//    edge t+NUM_STAGES-1 (NUM_STAGES cycles incl. the accept edge). Throughput 1/cycle.
//  - Outputs are stage N-1 registers directly (no comb path from inputs).
//  - data_result_out = op_high ? acc[2W-1:W] : acc[W-1:0].
//  - Overflow: xcpt_mul_out.xcpt_overflow=1 iff !op_high && acc[2W-1:W]!=0 &&
//    no fetch/decode xcpt; xcpt_mul_out.addr = PC of op.
//  - Upstream xcpt (fetch or decode valid): op still flows (valid), result forced 0,
//    no overflow raised; xcpt fields passed unchanged.
//  - stall_in=1: every stage register (incl. outputs) holds; instr_valid_in ignored.
//    Upstream must hold its op while stalled.
//  - flush_in=1: all stage valids cleared next edge; input op dropped; flush beats stall.
//  - Stage valid=0: data regs may hold garbage but outputs of invalid slot
//    carry valid=0 and xcpt valid bits 0.
//  - busy_out = OR of all stage valids (comb).
//  - Reset asserted mid-operation: all in-flight ops lost, same as reset state.
// STRUCTURE
//  - soc_pkg: mul_xcpt_t (existing), add MUL_NUM_STAGES default const,
//    mul_stage_t struct {valid, id, pc, dest, a, b, op_high, acc, xcpt_fetch, xcpt_decode}.
//  - One sub-module: mul_pipe_stage (params STAGE_IDX, C, W): one chunk add + register,
//    with stall/flush/reset; mul_pipe instantiates NUM_STAGES via generate and
//    computes final select/overflow in last stage.
// TESTING
//  1. Reset low 2 cycles -> all outputs 0, busy_out 0; release, idle -> valid_out stays 0.
//  2. a=7,b=6,op_high=0,id=3 -> 4 cycles later valid_out=1,data=42,id=3,no xcpt.
//  3. a=0xFFFFFFFF,b=2: op_high=0 -> data=0xFFFFFFFE, overflow=1; op_high=1 -> data=1, no xcpt.
//  4. Back-to-back 8 ops (a=i,b=i+1) -> 8 consecutive valid outputs in order, correct products.
//  5. Stall 3 cycles with 4 ops in flight -> outputs frozen, none lost/duplicated, then resume.
//  6. Flush with 3 ops in flight plus new input same cycle -> no valid_out for any of them,
//     busy_out 0 next cycle; op with decode xcpt -> data 0, decode xcpt passed, no overflow.

Source files
------------

// File: rtl/mul_pipe_pkg.sv
// Shared widths, exception records and the per-stage payload of the MUL pipeline.
// Every mul_pipe file imports this package.
package mul_pipe_pkg;

    localparam int ROB_ID_WIDTH   = 4;
    localparam int PC_WIDTH       = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int REG_DATA_WIDTH = 32;
    localparam int MUL_NUM_STAGES = 4;

    typedef struct packed {
        logic                xcpt_access_fault;
        logic [PC_WIDTH-1:0] addr;
    } fetch_xcpt_t;

    typedef struct packed {
        logic xcpt_illegal_instr;
    } decode_xcpt_t;

    typedef struct packed {
        logic                xcpt_overflow;
        logic [PC_WIDTH-1:0] addr;
    } mul_xcpt_t;

    typedef struct packed {
        logic                        valid;
        logic [ROB_ID_WIDTH-1:0]     id;
        logic [PC_WIDTH-1:0]         pc;
        logic [REG_ADDR_WIDTH-1:0]   dest;
        logic [REG_DATA_WIDTH-1:0]   a;
        logic [REG_DATA_WIDTH-1:0]   b;
        logic                        op_high;
        logic [2*REG_DATA_WIDTH-1:0] acc;
        fetch_xcpt_t                 xcpt_fetch;
        decode_xcpt_t                xcpt_decode;
    } mul_stage_t;

    function automatic logic has_upstream_xcpt(fetch_xcpt_t f, decode_xcpt_t d);
        return f.xcpt_access_fault | d.xcpt_illegal_instr;
    endfunction

endpackage

// File: rtl/mul_pipe_if.sv
// Issue-side and writeback-side signals of the MUL unit.
// The master modport drives ops in; the slave modport is the pipeline itself.
interface mul_pipe_if import mul_pipe_pkg::*; #(
    parameter int DATA_WIDTH = REG_DATA_WIDTH
);
    logic                      stall_in;
    logic                      flush_in;
    logic                      instr_valid_in;
    logic [ROB_ID_WIDTH-1:0]   instr_id_in;
    logic [PC_WIDTH-1:0]       program_counter_in;
    logic [REG_ADDR_WIDTH-1:0] dest_reg_in;
    logic [DATA_WIDTH-1:0]     src_a_in;
    logic [DATA_WIDTH-1:0]     src_b_in;
    logic                      op_high_in;
    fetch_xcpt_t               xcpt_fetch_in;
    decode_xcpt_t              xcpt_decode_in;

    logic                      instr_valid_out;
    logic [ROB_ID_WIDTH-1:0]   instr_id_out;
    logic [PC_WIDTH-1:0]       program_counter_out;
    logic [REG_ADDR_WIDTH-1:0] dest_reg_out;
    logic [DATA_WIDTH-1:0]     data_result_out;
    fetch_xcpt_t               xcpt_fetch_out;
    decode_xcpt_t              xcpt_decode_out;
    mul_xcpt_t                 xcpt_mul_out;
    logic                      busy_out;

    modport master (
        output stall_in, flush_in, instr_valid_in, instr_id_in, program_counter_in,
               dest_reg_in, src_a_in, src_b_in, op_high_in, xcpt_fetch_in, xcpt_decode_in,
        input  instr_valid_out, instr_id_out, program_counter_out, dest_reg_out,
               data_result_out, xcpt_fetch_out, xcpt_decode_out, xcpt_mul_out, busy_out
    );

    modport slave (
        input  stall_in, flush_in, instr_valid_in, instr_id_in, program_counter_in,
               dest_reg_in, src_a_in, src_b_in, op_high_in, xcpt_fetch_in, xcpt_decode_in,
        output instr_valid_out, instr_id_out, program_counter_out, dest_reg_out,
               data_result_out, xcpt_fetch_out, xcpt_decode_out, xcpt_mul_out, busy_out
    );

endinterface

// File: rtl/mul_pipe_stage.sv
// One multiplier stage: adds the partial product of one C-bit chunk of b into acc
// and registers the whole op record, honouring reset, flush and stall.
module mul_pipe_stage import mul_pipe_pkg::*; #(
    parameter int STAGE_IDX = 0,
    parameter int C         = 8,
    parameter int W         = 32
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       stall,
    input  logic       flush,
    input  mul_stage_t prev,
    output mul_stage_t cur
);

    localparam int W2    = 2 * W;
    localparam int SHIFT = STAGE_IDX * C;

    logic [W2-1:0] b_chunk;
    logic [W2-1:0] partial;
    mul_stage_t    next;

    // Widen before multiplying so the shifted partial product can never wrap.
    always_comb begin
        b_chunk  = W2'(prev.b[SHIFT +: C]);
        partial  = (W2'(prev.a) * b_chunk) << SHIFT;
        next     = prev;
        next.acc = prev.acc + partial;
    end

    // Flush only needs to kill the valid bit; payload of a dead slot is never observed.
    always_ff @(posedge clock) begin
        if (!reset) begin
            cur <= '0;
        end else if (flush) begin
            cur.valid <= 1'b0;
        end else if (!stall) begin
            cur <= next;
        end
    end

endmodule

// File: rtl/mul_pipe.sv
// Registered iterative-chunk unsigned multiplier for the MUL functional unit,
// carrying ROB metadata and exceptions alongside and raising overflow at the end.
module mul_pipe import mul_pipe_pkg::*; #(
    parameter int NUM_STAGES = MUL_NUM_STAGES,
    parameter int DATA_WIDTH = REG_DATA_WIDTH
) (
    input logic         clock,
    input logic         reset,
    mul_pipe_if.slave   bus
);

    localparam int C = DATA_WIDTH / NUM_STAGES;

    generate
        if ((DATA_WIDTH % NUM_STAGES) != 0 || DATA_WIDTH != REG_DATA_WIDTH) begin : g_bad_params
            $error("mul_pipe: DATA_WIDTH must equal REG_DATA_WIDTH and be a multiple of NUM_STAGES");
        end
    endgenerate

    mul_stage_t chain [NUM_STAGES+1];
    mul_stage_t last;
    logic       upstream_xcpt;
    logic       any_valid;

    always_comb begin
        chain[0]             = '0;
        chain[0].valid       = bus.instr_valid_in;
        chain[0].id          = bus.instr_id_in;
        chain[0].pc          = bus.program_counter_in;
        chain[0].dest        = bus.dest_reg_in;
        chain[0].a           = bus.src_a_in;
        chain[0].b           = bus.src_b_in;
        chain[0].op_high     = bus.op_high_in;
        chain[0].xcpt_fetch  = bus.xcpt_fetch_in;
        chain[0].xcpt_decode = bus.xcpt_decode_in;
    end

    generate
        for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
            mul_pipe_stage #(
                .STAGE_IDX (k),
                .C         (C),
                .W         (DATA_WIDTH)
            ) u_stage (
                .clock (clock),
                .reset (reset),
                .stall (bus.stall_in),
                .flush (bus.flush_in),
                .prev  (chain[k]),
                .cur   (chain[k+1])
            );
        end
    endgenerate

    always_comb begin
        any_valid = 1'b0;
        for (int k = 1; k <= NUM_STAGES; k++) begin
            any_valid = any_valid | chain[k].valid;
        end
    end

    assign last          = chain[NUM_STAGES];
    assign upstream_xcpt = has_upstream_xcpt(last.xcpt_fetch, last.xcpt_decode);

    // Everything below is a pure function of the last stage register; an op that
    // already faulted upstream yields zero data and never reports overflow.
    assign bus.instr_valid_out          = last.valid;
    assign bus.instr_id_out             = last.id;
    assign bus.program_counter_out      = last.pc;
    assign bus.dest_reg_out             = last.dest;
    assign bus.data_result_out          = upstream_xcpt ? '0 :
                                          last.op_high  ? last.acc[2*DATA_WIDTH-1:DATA_WIDTH]
                                                        : last.acc[DATA_WIDTH-1:0];
    assign bus.xcpt_fetch_out           = last.valid ? last.xcpt_fetch  : '0;
    assign bus.xcpt_decode_out          = last.valid ? last.xcpt_decode : '0;
    assign bus.xcpt_mul_out.xcpt_overflow = last.valid && !last.op_high && !upstream_xcpt &&
                                            (last.acc[2*DATA_WIDTH-1:DATA_WIDTH] != '0);
    assign bus.xcpt_mul_out.addr        = last.pc;
    assign bus.busy_out                 = any_valid;

endmodule

// File: tb/tb_mul_pipe.sv
// Self-checking bench for mul_pipe: directed table, hand-written stall/flush/reset
// sequences and random traffic, all scored against a queue-based latency model.
module tb_mul_pipe;
    import mul_pipe_pkg::*;

    localparam int N = MUL_NUM_STAGES;
    localparam int W = REG_DATA_WIDTH;

    logic clock = 1'b0;
    logic reset = 1'b0;

    mul_pipe_if #(.DATA_WIDTH(W)) bus ();

    mul_pipe #(.NUM_STAGES(N), .DATA_WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [W-1:0]              data;
        logic [ROB_ID_WIDTH-1:0]   id;
        logic [PC_WIDTH-1:0]       pc;
        logic [REG_ADDR_WIDTH-1:0] dest;
        logic                      ovf;
        logic                      fetch_x;
        logic                      dec_x;
        int                        age;
    } model_op_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         op_high;
        logic         dec_x;
        logic [W-1:0] exp_data;
        logic         exp_ovf;
    } vec_t;

    model_op_t inflight[$];
    int n_vectors     = 0;
    int n_miscompares = 0;

    function automatic model_op_t predict(logic [W-1:0] a, logic [W-1:0] b, logic op_high,
                                          logic [ROB_ID_WIDTH-1:0] id, logic [PC_WIDTH-1:0] pc,
                                          logic [REG_ADDR_WIDTH-1:0] dest, logic fx, logic dx);
        model_op_t     m;
        logic [2*W-1:0] prod;
        prod      = (2*W)'(a) * (2*W)'(b);
        m.id      = id;
        m.pc      = pc;
        m.dest    = dest;
        m.fetch_x = fx;
        m.dec_x   = dx;
        m.age     = 1;
        if (fx || dx) begin
            m.data = '0;
            m.ovf  = 1'b0;
        end else begin
            m.data = op_high ? prod[2*W-1:W] : prod[W-1:0];
            m.ovf  = !op_high && (prod[2*W-1:W] != '0);
        end
        return m;
    endfunction

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic valid, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic op_high, input logic [ROB_ID_WIDTH-1:0] id,
                                  input logic fx, input logic dx);
        bus.instr_valid_in                   = valid;
        bus.src_a_in                         = a;
        bus.src_b_in                         = b;
        bus.op_high_in                       = op_high;
        bus.instr_id_in                      = id;
        bus.program_counter_in               = 32'h0000_1000 + 32'(id) * 4;
        bus.dest_reg_in                      = REG_ADDR_WIDTH'(id) + 5'd1;
        bus.xcpt_fetch_in.xcpt_access_fault  = fx;
        bus.xcpt_fetch_in.addr               = fx ? bus.program_counter_in : '0;
        bus.xcpt_decode_in.xcpt_illegal_instr = dx;
    endtask

    // Model: each accepted op ages once per non-stalled edge and is visible at age N.
    task automatic update_model();
        if (!reset || bus.flush_in) begin
            inflight.delete();
        end else if (!bus.stall_in) begin
            foreach (inflight[i]) inflight[i].age++;
            if (inflight.size() > 0 && inflight[0].age > N) void'(inflight.pop_front());
            if (bus.instr_valid_in)
                inflight.push_back(predict(bus.src_a_in, bus.src_b_in, bus.op_high_in,
                                           bus.instr_id_in, bus.program_counter_in, bus.dest_reg_in,
                                           bus.xcpt_fetch_in.xcpt_access_fault,
                                           bus.xcpt_decode_in.xcpt_illegal_instr));
        end
    endtask

    task automatic check_output();
        logic exp_valid;
        exp_valid = (inflight.size() > 0) && (inflight[0].age == N);
        check("valid_out", 64'(bus.instr_valid_out), 64'(exp_valid));
        check("busy_out", 64'(bus.busy_out), 64'(inflight.size() > 0));
        if (exp_valid) begin
            check("data", 64'(bus.data_result_out), 64'(inflight[0].data));
            check("id", 64'(bus.instr_id_out), 64'(inflight[0].id));
            check("pc", 64'(bus.program_counter_out), 64'(inflight[0].pc));
            check("dest", 64'(bus.dest_reg_out), 64'(inflight[0].dest));
            check("overflow", 64'(bus.xcpt_mul_out.xcpt_overflow), 64'(inflight[0].ovf));
            if (inflight[0].ovf) check("overflow_addr", 64'(bus.xcpt_mul_out.addr), 64'(inflight[0].pc));
            check("fetch_xcpt", 64'(bus.xcpt_fetch_out.xcpt_access_fault), 64'(inflight[0].fetch_x));
            check("decode_xcpt", 64'(bus.xcpt_decode_out.xcpt_illegal_instr), 64'(inflight[0].dec_x));
        end else begin
            check("idle_overflow", 64'(bus.xcpt_mul_out.xcpt_overflow), 64'd0);
            check("idle_fetch_xcpt", 64'(bus.xcpt_fetch_out.xcpt_access_fault), 64'd0);
            check("idle_decode_xcpt", 64'(bus.xcpt_decode_out.xcpt_illegal_instr), 64'd0);
        end
        if (!reset) begin
            check("reset_data", 64'(bus.data_result_out), 64'd0);
            check("reset_id", 64'(bus.instr_id_out), 64'd0);
            check("reset_pc", 64'(bus.program_counter_out), 64'd0);
            check("reset_dest", 64'(bus.dest_reg_out), 64'd0);
            check("reset_ovf_addr", 64'(bus.xcpt_mul_out.addr), 64'd0);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        update_model();
        #1;
        check_output();
    endtask

    task automatic idle(input int cycles);
        apply_stimulus(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
        repeat (cycles) tick();
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{32'd7,         32'd6,         1'b0, 1'b0, 32'd42,        1'b0};
        vecs[1] = '{32'hFFFF_FFFF, 32'd2,         1'b0, 1'b0, 32'hFFFF_FFFE, 1'b1};
        vecs[2] = '{32'hFFFF_FFFF, 32'd2,         1'b1, 1'b0, 32'd1,         1'b0};
        vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0};
        vecs[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd1,         1'b1};
        vecs[5] = '{32'hFFFF_FFFF, 32'd2,         1'b0, 1'b1, 32'd0,         1'b0};
        vecs[6] = '{32'd0,         32'hDEAD_BEEF, 1'b0, 1'b0, 32'd0,         1'b0};
        vecs[7] = '{32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0, 32'd0,         1'b1};

        bus.stall_in = 1'b0;
        bus.flush_in = 1'b0;
        apply_stimulus(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);

        // Reset held for two edges, then idle.
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        idle(3);

        // Directed table: one op at a time, result checked against the table entry.
        for (int v = 0; v < 8; v++) begin
            apply_stimulus(1'b1, vecs[v].a, vecs[v].b, vecs[v].op_high, 4'(v + 3), 1'b0, vecs[v].dec_x);
            tick();
            apply_stimulus(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
            repeat (N - 1) tick();
            check("table_valid", 64'(bus.instr_valid_out), 64'd1);
            check("table_data", 64'(bus.data_result_out), 64'(vecs[v].exp_data));
            check("table_ovf", 64'(bus.xcpt_mul_out.xcpt_overflow), 64'(vecs[v].exp_ovf));
            check("table_id", 64'(bus.instr_id_out), 64'(v + 3));
            tick();
        end

        // Back-to-back ops.
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(1'b1, 32'(i), 32'(i + 1), 1'b0, 4'(i), 1'b0, 1'b0);
            tick();
        end
        idle(N + 1);

        // Stall with four ops in flight; the held input must not be taken.
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b1, 32'(100 + i), 32'(3 + i), 1'b0, 4'(i + 8), 1'b0, 1'b0);
            tick();
        end
        apply_stimulus(1'b1, 32'd55, 32'd66, 1'b0, 4'd13, 1'b0, 1'b0);
        bus.stall_in = 1'b1;
        repeat (3) tick();
        bus.stall_in = 1'b0;
        tick();
        idle(N + 1);

        // Flush with three ops in flight and a new op on the same edge.
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b1, 32'(20 + i), 32'(30 + i), 1'b0, 4'(i), 1'b0, 1'b0);
            tick();
        end
        apply_stimulus(1'b1, 32'd9, 32'd9, 1'b0, 4'd7, 1'b0, 1'b0);
        bus.flush_in = 1'b1;
        bus.stall_in = 1'b1;
        tick();
        bus.flush_in = 1'b0;
        bus.stall_in = 1'b0;
        check("flush_busy", 64'(bus.busy_out), 64'd0);
        idle(N + 1);

        // Reset asserted mid-operation.
        for (int i = 0; i < 2; i++) begin
            apply_stimulus(1'b1, 32'(40 + i), 32'd5, 1'b0, 4'(i), 1'b0, 1'b0);
            tick();
        end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        idle(N + 1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            a = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
            b = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
            apply_stimulus($urandom_range(0, 1) == 1, a, b, $urandom_range(0, 1) == 1,
                           ROB_ID_WIDTH'($urandom), $urandom_range(0, 9) == 0,
                           $urandom_range(0, 9) == 0);
            bus.stall_in = ($urandom_range(0, 4) == 0);
            bus.flush_in = ($urandom_range(0, 19) == 0);
            tick();
        end
        bus.stall_in = 1'b0;
        bus.flush_in = 1'b0;
        idle(N + 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
